// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared count type, 640x480@60 defaults and span arithmetic for the VGA timing path
package vga_timing_pkg;

   typedef logic [9:0] vga_cnt_t;

   localparam int VGA_CW       = $bits(vga_cnt_t);
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with sync/active decoded from the next count
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE = VGA_H_ACTIVE,
   parameter int   FP     = VGA_H_FP,
   parameter int   SYNC   = VGA_H_SYNC,
   parameter int   BP     = VGA_H_BP,
   parameter logic POL    = 1'b0,
   parameter int   CW     = VGA_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   output logic [CW-1:0] cnt,
   output logic          sync,
   output logic          active,
   output logic          wrap
);

   localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

   localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

   logic [CW-1:0] cnt_nxt;

   // Explicit compare against LAST so non-power-of-two totals never rely on overflow
   always_comb begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   assign wrap = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= LAST;
         sync   <= ~POL;
         active <= 1'b0;
      end else if (adv) begin
         cnt    <= cnt_nxt;
         sync   <= (cnt_nxt >= SYNC_BEG && cnt_nxt < SYNC_END) ? POL : ~POL;
         active <= (cnt_nxt < ACT_END);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing source; VGA_TIMING_CE_EN adds the pix_ce pixel clock enable
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = VGA_H_ACTIVE,
   parameter int   H_FP      = VGA_H_FP,
   parameter int   H_SYNC    = VGA_H_SYNC,
   parameter int   H_BP      = VGA_H_BP,
   parameter int   V_ACTIVE  = VGA_V_ACTIVE,
   parameter int   V_FP      = VGA_V_FP,
   parameter int   V_SYNC    = VGA_V_SYNC,
   parameter int   V_BP      = VGA_V_BP,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CW        = VGA_CW
) (
   input  logic          clk,
   input  logic          rst,
`ifdef VGA_TIMING_CE_EN
   input  logic          pix_ce,
`endif
   output logic [CW-1:0] hcount_out,
   output logic [CW-1:0] vcount_out,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          vga_active_out,
   output logic          line_start_out,
   output logic          frame_start_out
);

   localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (H_TOTAL > 2**CW) begin : g_h_too_wide
      $error("vga_timing_gen: H_TOTAL %0d does not fit in CW=%0d", H_TOTAL, CW);
   end
   if (V_TOTAL > 2**CW) begin : g_v_too_wide
      $error("vga_timing_gen: V_TOTAL %0d does not fit in CW=%0d", V_TOTAL, CW);
   end

   logic ce;
`ifdef VGA_TIMING_CE_EN
   assign ce = pix_ce;
`else
   assign ce = 1'b1;
`endif

   logic h_active, v_active, h_wrap, v_wrap;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .CW(CW)
   ) u_h (
      .clk(clk), .rst(rst), .adv(ce),
      .cnt(hcount_out), .sync(hsync_out), .active(h_active), .wrap(h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .CW(CW)
   ) u_v (
      .clk(clk), .rst(rst), .adv(ce && h_wrap),
      .cnt(vcount_out), .sync(vsync_out), .active(v_active), .wrap(v_wrap)
   );

   assign vga_active_out = h_active && v_active;

   // Strobes are re-evaluated every clk so they fall on the first clk without ce
   always_ff @(posedge clk) begin
      if (rst) begin
         line_start_out  <= 1'b0;
         frame_start_out <= 1'b0;
      end else begin
         line_start_out  <= ce && h_wrap;
         frame_start_out <= ce && h_wrap && v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: default 640x480 instance plus a tiny 15x13 active-high-sync instance
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_s = 1'b1;
   logic pix_ce = 1'b1;

   logic [9:0] hc, vc;
   logic       hs, vs, act, ls, fs;
   logic [3:0] hc_s, vc_s;
   logic       hs_s, vs_s, act_s, ls_s, fs_s;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   vga_timing_gen dut (
      .clk(clk), .rst(rst),
`ifdef VGA_TIMING_CE_EN
      .pix_ce(pix_ce),
`endif
      .hcount_out(hc), .vcount_out(vc), .hsync_out(hs), .vsync_out(vs),
      .vga_active_out(act), .line_start_out(ls), .frame_start_out(fs)
   );

   // 8+2+3+2 = 15 pixels, 6+2+2+3 = 13 lines, frame = 195 clks, sync active-high
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
   ) dut_s (
      .clk(clk), .rst(rst_s),
`ifdef VGA_TIMING_CE_EN
      .pix_ce(pix_ce),
`endif
      .hcount_out(hc_s), .vcount_out(vc_s), .hsync_out(hs_s), .vsync_out(vs_s),
      .vga_active_out(act_s), .line_start_out(ls_s), .frame_start_out(fs_s)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rst_s = 1'b1;
      repeat (5) tick();
      tests++; if (hc !== 10'd799) begin fails++; $display("FAIL reset_hcount got %0d want 799", hc); end
      tests++; if (vc !== 10'd524) begin fails++; $display("FAIL reset_vcount got %0d want 524", vc); end
      tests++; if ({act, hs, vs, ls, fs} !== 5'b01100) begin fails++; $display("FAIL reset_flags act/hs/vs/ls/fs got %b want 01100", {act, hs, vs, ls, fs}); end
      tests++; if ({hc_s, vc_s} !== {4'd14, 4'd12}) begin fails++; $display("FAIL reset_small_counts got %0d/%0d want 14/12", hc_s, vc_s); end
      tests++; if ({act_s, hs_s, vs_s} !== 3'b000) begin fails++; $display("FAIL reset_small_pol act/hs/vs got %b want 000", {act_s, hs_s, vs_s}); end
      rst = 1'b0;
      rst_s = 1'b0;
      tick();
      tests++; if ({hc, vc} !== 20'd0) begin fails++; $display("FAIL release_counts got %0d/%0d want 0/0", hc, vc); end
      tests++; if ({act, ls, fs} !== 3'b111) begin fails++; $display("FAIL release_strobes act/ls/fs got %b want 111", {act, ls, fs}); end
      tests++; if ({hc_s, vc_s, act_s, fs_s} !== 10'b0000_0000_11) begin fails++; $display("FAIL release_small got h%0d v%0d act%b fs%b want h0 v0 act1 fs1", hc_s, vc_s, act_s, fs_s); end
   endtask

   task automatic test_line();
      int bad_cnt = 0;
      int bad_strobe = 0;
      int act_n = 0;
      int hs_n = 0;
      int hs_first = -1;
      int hs_last = -1;
      logic act640 = 1'b1;
      for (int k = 0; k <= 800; k++) begin
         if (k > 0) tick();
         if (hc !== 10'(k % 800) || vc !== 10'(k / 800)) bad_cnt++;
         if (ls !== (k % 800 == 0) || fs !== (k == 0)) bad_strobe++;
         if (k < 800) begin
            if (act === 1'b1) act_n++;
            if (hs === 1'b0) begin
               hs_n++;
               if (hs_first < 0) hs_first = k;
               hs_last = k;
            end
            if (k == 640) act640 = act;
         end
      end
      tests++; if (bad_cnt != 0) begin fails++; $display("FAIL line_counts bad samples %0d want 0", bad_cnt); end
      tests++; if (bad_strobe != 0) begin fails++; $display("FAIL line_strobes bad samples %0d want 0", bad_strobe); end
      tests++; if (act_n != 640) begin fails++; $display("FAIL line_active_len got %0d want 640", act_n); end
      tests++; if (act640 !== 1'b0) begin fails++; $display("FAIL line_active_h640 got %b want 0", act640); end
      tests++; if (hs_n != 96) begin fails++; $display("FAIL line_hsync_len got %0d want 96", hs_n); end
      tests++; if (hs_first != 656 || hs_last != 751) begin fails++; $display("FAIL line_hsync_span got %0d..%0d want 656..751", hs_first, hs_last); end
      tests++; if (vc !== 10'd1 || ls !== 1'b1) begin fails++; $display("FAIL line_wrap got v%0d ls%b want v1 ls1", vc, ls); end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (hc === 10'd300) found = 1;
         else tick();
      end
      tests++; if (!found) begin fails++; $display("FAIL midreset_wait got timeout want h=300"); end
      rst = 1'b1;
      tick();
      tests++; if ({hc, vc} !== {10'd799, 10'd524}) begin fails++; $display("FAIL midreset_counts got %0d/%0d want 799/524", hc, vc); end
      tests++; if ({act, hs, vs, ls, fs} !== 5'b01100) begin fails++; $display("FAIL midreset_flags got %b want 01100", {act, hs, vs, ls, fs}); end
      rst = 1'b0;
      tick();
      tests++; if ({hc, vc, fs, ls} !== 22'b11) begin fails++; $display("FAIL midreset_resume got h%0d v%0d fs%b ls%b want h0 v0 fs1 ls1", hc, vc, fs, ls); end
   endtask

   task automatic test_frame_small();
      bit found = 0;
      int bad_cnt = 0;
      int act_n = 0;
      int hs_n = 0;
      int vs_n = 0;
      int vs_first = -1;
      int ls_n = 0;
      int fs_n = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (fs_s === 1'b1) found = 1;
         else tick();
      end
      tests++; if (!found) begin fails++; $display("FAIL frame_sync got timeout want frame_start"); end
      for (int k = 0; k < 195; k++) begin
         if (k > 0) tick();
         if (hc_s !== 4'(k % 15) || vc_s !== 4'(k / 15)) bad_cnt++;
         if (act_s === 1'b1) act_n++;
         if (hs_s === 1'b1) hs_n++;
         if (vs_s === 1'b1) begin
            vs_n++;
            if (vs_first < 0) vs_first = k;
         end
         if (ls_s === 1'b1) ls_n++;
         if (fs_s === 1'b1) fs_n++;
      end
      tick();
      tests++; if (bad_cnt != 0) begin fails++; $display("FAIL frame_counts bad samples %0d want 0", bad_cnt); end
      tests++; if (act_n != 48) begin fails++; $display("FAIL frame_active got %0d want 48", act_n); end
      tests++; if (hs_n != 39) begin fails++; $display("FAIL frame_hsync_hi got %0d want 39", hs_n); end
      tests++; if (vs_n != 30 || vs_first != 120) begin fails++; $display("FAIL frame_vsync got %0d from %0d want 30 from 120", vs_n, vs_first); end
      tests++; if (ls_n != 13 || fs_n != 1) begin fails++; $display("FAIL frame_strobe_counts got ls%0d fs%0d want ls13 fs1", ls_n, fs_n); end
      tests++; if (fs_s !== 1'b1) begin fails++; $display("FAIL frame_period got fs%b at 195 want 1", fs_s); end
   endtask

   task automatic test_mid_reset_small();
      bit found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (hc_s === 4'd5 && vc_s === 4'd3) found = 1;
         else tick();
      end
      tests++; if (!found) begin fails++; $display("FAIL small_midreset_wait got timeout want (5,3)"); end
      rst_s = 1'b1;
      tick();
      tests++; if ({hc_s, vc_s, act_s, hs_s, vs_s, ls_s, fs_s} !== {4'd14, 4'd12, 5'b00000}) begin fails++; $display("FAIL small_midreset got h%0d v%0d flags %b want h14 v12 flags 00000", hc_s, vc_s, {act_s, hs_s, vs_s, ls_s, fs_s}); end
      rst_s = 1'b0;
      tick();
      tests++; if ({hc_s, vc_s, act_s, fs_s} !== 10'b0000_0000_11) begin fails++; $display("FAIL small_resume got h%0d v%0d act%b fs%b want h0 v0 act1 fs1", hc_s, vc_s, act_s, fs_s); end
   endtask

`ifdef VGA_TIMING_CE_EN
   task automatic test_ce();
      bit found = 0;
      int fs_n = 0;
      int ls_n = 0;
      logic [3:0] h_hold, v_hold;
      logic [9:0] hd_hold;
      for (int i = 0; i < 1000 && !found; i++) begin
         if (fs_s === 1'b1 && pix_ce === 1'b1) found = 1;
         else begin
            pix_ce = ~pix_ce;
            tick();
         end
      end
      tests++; if (!found) begin fails++; $display("FAIL ce_sync got timeout want frame_start"); end
      ls_n = 1;
      for (int k = 1; k <= 390; k++) begin
         pix_ce = ~pix_ce;
         tick();
         if (k < 390) begin
            if (fs_s === 1'b1) fs_n++;
            if (ls_s === 1'b1) ls_n++;
         end
      end
      tests++; if (fs_n != 0) begin fails++; $display("FAIL ce_fs_inside got %0d want 0", fs_n); end
      tests++; if (ls_n != 13) begin fails++; $display("FAIL ce_ls_count got %0d want 13", ls_n); end
      tests++; if (fs_s !== 1'b1) begin fails++; $display("FAIL ce_period got fs%b at 390 want 1", fs_s); end
      h_hold = hc_s;
      v_hold = vc_s;
      hd_hold = hc;
      pix_ce = 1'b0;
      repeat (5) tick();
      tests++; if (hc_s !== h_hold || vc_s !== v_hold || hc !== hd_hold) begin fails++; $display("FAIL ce_freeze got %0d/%0d/%0d want %0d/%0d/%0d", hc_s, vc_s, hc, h_hold, v_hold, hd_hold); end
      tests++; if ({ls_s, fs_s, ls, fs} !== 4'b0000) begin fails++; $display("FAIL ce_freeze_strobes got %b want 0000", {ls_s, fs_s, ls, fs}); end
      pix_ce = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_mid_reset();
      test_frame_small();
      test_mid_reset_small();
`ifdef VGA_TIMING_CE_EN
      test_ce();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
